// File: rtl/seg7_readback_if.sv
// Bus bundle for the 7-segment readback decoder: multiplexed display lines in,
// decoded frame out on a valid/ready handshake.
interface seg7_readback_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();

  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    frame_err;
  logic                    frame_valid;
  logic                    frame_ready;
  logic                    overflow;
  logic                    timeout_pulse;

  // Decoder side: samples the display bus and produces frames.
  modport master (
    input  seg,
    input  digit_en,
    input  frame_ready,
    output bcd_out,
    output blank_mask,
    output frame_err,
    output frame_valid,
    output overflow,
    output timeout_pulse
  );

  // Display driver / frame consumer side.
  modport slave (
    output seg,
    output digit_en,
    output frame_ready,
    input  bcd_out,
    input  blank_mask,
    input  frame_err,
    input  frame_valid,
    input  overflow,
    input  timeout_pulse
  );

endinterface

// File: rtl/seg7_readback_decoder.sv
// Watches a multiplexed active-low 7-segment bus, decodes settled digits back to BCD
// and assembles them into frames offered on a valid/ready handshake.
module seg7_readback_decoder #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seg7_readback_if.master        bus
);

  localparam int unsigned SampW = NUM_DIGITS + 7;
  localparam int unsigned CntW  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam int unsigned SelW  = $clog2(NUM_DIGITS);

  localparam logic [CntW-1:0]  CntMax   = CntW'(SETTLE_CYCLES);
  // cnt moves from this value to SETTLE_CYCLES-1 on the capture edge
  localparam logic [CntW-1:0]  CntFire  = CntW'(SETTLE_CYCLES - 2);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);

  typedef enum logic [0:0] {StCollect, StHold} state_e;

  // Returns {err, blank, bcd}; blank and illegal patterns read back as 4'hF.
  function automatic logic [5:0] decode_seg(input logic [6:0] pat);
    logic [5:0] r;
    case (pat)
      7'b1000000: r = {2'b00, 4'd0};
      7'b1111001: r = {2'b00, 4'd1};
      7'b0100100: r = {2'b00, 4'd2};
      7'b0110000: r = {2'b00, 4'd3};
      7'b0011001: r = {2'b00, 4'd4};
      7'b0010010: r = {2'b00, 4'd5};
      7'b0000010: r = {2'b00, 4'd6};
      7'b1111000: r = {2'b00, 4'd7};
      7'b0000000: r = {2'b00, 4'd8};
      7'b0011000: r = {2'b00, 4'd9};
      7'b1111111: r = {2'b01, 4'hF};
      default:    r = {2'b10, 4'hF};
    endcase
    return r;
  endfunction

  logic [SampW-1:0]            port_val;
  logic [SampW-1:0]            s_q;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]       got_q, got_d;
  logic [NUM_DIGITS-1:0][3:0]  slot_q, slot_d;
  logic [NUM_DIGITS-1:0]       blank_q, blank_d;
  logic [NUM_DIGITS-1:0]       err_q, err_d;
  logic [IdleW-1:0]            idle_q, idle_d;
  state_e                      state_q, state_d;

  logic [4*NUM_DIGITS-1:0]     bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]       mask_q, mask_d;
  logic                        ferr_q, ferr_d;
  logic                        valid_q, valid_d;
  logic                        ovf_q, ovf_d;
  logic                        tpulse_q, tpulse_d;

  logic                        same;
  logic                        low_seen;
  logic                        low_multi;
  logic [SelW-1:0]             sel;
  logic                        capture;
  logic                        complete;
  logic                        timeout_fire;
  logic                        accept;
  logic                        load;
  logic [5:0]                  dec;

  assign port_val = {bus.digit_en, bus.seg};
  assign same     = (port_val == s_q);
  assign complete = &got_q;
  assign accept   = valid_q & bus.frame_ready;
  assign dec      = decode_seg(bus.seg);

  // Settle counter and one-hot-low enable detection
  always_comb begin
    cnt_d     = '0;
    low_seen  = 1'b0;
    low_multi = 1'b0;
    sel       = '0;
    if (same) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!bus.digit_en[i]) begin
        if (low_seen) low_multi = 1'b1;
        low_seen = 1'b1;
        sel      = SelW'(i);
      end
    end
    capture = same && (cnt_q == CntFire) && low_seen && !low_multi;
  end

  // Idle timer: discards a partial frame that stops making progress
  always_comb begin
    idle_d       = idle_q;
    tpulse_d     = 1'b0;
    timeout_fire = 1'b0;
    if (capture || (got_q == '0) || complete) begin
      idle_d = '0;
    end else if (idle_q == IdleLast) begin
      idle_d       = '0;
      tpulse_d     = 1'b1;
      timeout_fire = 1'b1;
    end else begin
      idle_d = idle_q + 1'b1;
    end
  end

  // Slot storage; every completion empties got whether the frame is loaded or dropped
  always_comb begin
    slot_d  = slot_q;
    blank_d = blank_q;
    err_d   = err_q;
    got_d   = got_q;
    if (complete || timeout_fire) begin
      got_d = '0;
    end
    if (capture) begin
      slot_d[sel]  = dec[3:0];
      blank_d[sel] = dec[4];
      err_d[sel]   = dec[5];
      got_d[sel]   = 1'b1;
    end
  end

  // Frame output FSM
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    load    = 1'b0;
    case (state_q)
      StCollect: begin
        if (complete) begin
          load    = 1'b1;
          valid_d = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (complete) begin
          if (accept) load = 1'b1;
          else        ovf_d = 1'b1;
        end else if (accept) begin
          valid_d = 1'b0;
          state_d = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase

    bcd_d  = bcd_q;
    mask_d = mask_q;
    ferr_d = ferr_q;
    if (load) begin
      bcd_d  = slot_q;
      mask_d = blank_q;
      ferr_d = |err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q      <= '0;
      cnt_q    <= '0;
      got_q    <= '0;
      slot_q   <= '0;
      blank_q  <= '0;
      err_q    <= '0;
      idle_q   <= '0;
      state_q  <= StCollect;
      bcd_q    <= '0;
      mask_q   <= '0;
      ferr_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      tpulse_q <= 1'b0;
    end else begin
      s_q      <= port_val;
      cnt_q    <= cnt_d;
      got_q    <= got_d;
      slot_q   <= slot_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      idle_q   <= idle_d;
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      mask_q   <= mask_d;
      ferr_q   <= ferr_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      tpulse_q <= tpulse_d;
    end
  end

  assign bus.bcd_out       = bcd_q;
  assign bus.blank_mask    = mask_q;
  assign bus.frame_err     = ferr_q;
  assign bus.frame_valid   = valid_q;
  assign bus.overflow      = ovf_q;
  assign bus.timeout_pulse = tpulse_q;

endmodule
